instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch and PC sequencing stage for the non-pipelined MIPS core. It sits directly upstream of the main control decoder: it fetches one 32-bit word from instruction memory over a ready handshake and holds it in the instruction register. It presents `opcode` to the decoder, then applies the decoder's `jump`/`branch` result (with the ALU `zero` flag) to compute the next PC.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset; must be word-aligned.
- `clk` input 1 system clock, rising-edge active.
- `rst_n` input 1 asynchronous active-low reset.
- `imem_req` output 1 fetch request to instruction memory.
- `imem_addr` output 32 fetch address; always equals `pc`.
- `imem_ready` input 1 memory has valid `imem_rdata` this cycle.
- `imem_rdata` input 32 instruction word from memory.
- `jump` input 1 from control decoder: take jump.
- `branch` input 1 from control decoder: instruction is beq.
- `zero` input 1 ALU zero flag.
- `stall` input 1 hold current instruction in execute.
- `pc` output 32 address of the current instruction.
- `pc_plus4` output 32 `pc + 4`, combinational.
- `instr` output 32 instruction register.
- `opcode` output 6 `instr[31:26]`, to control decoder.
- `instr_valid` output 1 `instr` is live and being executed.
- `retired` output 32 count of completed instructions.

## Operation
- FSM states: IDLE, FETCH, EXEC. Reset state is IDLE.
- IDLE: all strobes low. Unconditional move to FETCH on the next rising edge. This guarantees no request is issued in the first cycle after reset release.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until accepted.
  - On `imem_ready`=1, latch `imem_rdata` into `instr` and go to EXEC.
  - Otherwise remain in FETCH.
- EXEC:
  - `instr_valid`=1. The decoder and datapath evaluate combinationally from `opcode`/`instr`.
  - If `stall`=1, hold the state; `pc`, `instr` and `retired` are unchanged.
  - If `stall`=0, load the next PC, increment `retired`, and go to FETCH.
- Next PC, in priority order:
  - `jump`=1: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - else `branch`=1 and `zero`=1: `pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
  - else `pc_plus4`.
- Arithmetic: all PC additions are 32-bit modulo 2^32 and wrap silently; `pc[1:0]` stays 00.
- `imem_ready` outside FETCH is ignored. `jump`/`branch`/`zero`/`stall` outside EXEC are ignored.
- `retired` wraps from 32'hFFFF_FFFF to 0.
- Reset values:
  - `pc`=RESET_PC; `instr`=0; `retired`=0.
  - `imem_req`=0; `instr_valid`=0.
  - `opcode`=0. Not a valid instruction, because `instr_valid`=0.

## Timing
- `imem_req`, `imem_addr` and `instr_valid` are decoded from registered state and `pc`; they are glitch-free with respect to inputs.
- Minimum two cycles per instruction: one FETCH cycle with zero-wait memory, one EXEC cycle. Each memory wait cycle adds one.
- `instr` and `opcode` update on the edge that samples `imem_ready`=1. `instr_valid` rises in the same cycle.
- Next PC is sampled on the EXEC-exit edge. The new `imem_addr` is presented in the immediately following FETCH cycle.
- Reset asserted in any state, including mid-FETCH with `imem_req` high:
  - All registers return to reset values asynchronously.
  - `imem_req` drops without waiting for a clock.
  - A pending `imem_ready` is discarded.
- Reset release: one IDLE cycle, then FETCH at RESET_PC.

## Test plan
- Reset, then zero-wait memory returning 32'h0000_0000 (add) at every address -> `imem_addr` sequence 0, 4, 8; `instr_valid` high every second cycle; `retired`=3 after three EXEC exits.
- Memory with 3 wait cycles at pc=0 -> `imem_req` held 4 cycles with `imem_addr`=0; `instr` latched only on the `imem_ready` edge.
- beq at pc=32'h40 with imm=16'hFFFE, `branch`=1, `zero`=1 -> next `imem_addr`=32'h3C. Same instruction with `zero`=0 -> next `imem_addr`=32'h44.
- `jump`=1 at pc=32'h1000_0000, instr[25:0]=26'h0000100 -> next `imem_addr`=32'h1000_0400. `jump`=1 together with `branch`=`zero`=1 -> jump target wins.
- `stall`=1 for 5 EXEC cycles -> `pc`, `instr` and `retired` frozen; `imem_req`=0 throughout. Exactly one retire when `stall` drops.
- Wrap and reset cases:
  - RESET_PC=32'hFFFF_FFFC with a non-branch instruction -> next `imem_addr`=0.
  - Assert `rst_n`=0 mid-FETCH -> `imem_req`=0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
//-----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch and PC sequencing stage for the non-pipelined MIPS core.
// One 32-bit word is fetched from instruction memory over a ready handshake
// and held in the instruction register while the downstream decoder and
// datapath execute it combinationally. When execution completes, the
// decoder's jump/branch result and the ALU zero flag select the next PC.
//
// Sequence per instruction: FETCH (one cycle plus memory wait cycles), then
// EXEC (one cycle plus stall cycles). After reset one IDLE cycle is spent
// before the first fetch so that no request appears right after release.
//
// Parameters
//   RESET_PC     PC loaded on reset (word-aligned)
//
// Ports
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   imem_req     fetch request to instruction memory (FETCH only)
//   imem_addr    fetch address, always equal to pc
//   imem_ready   memory presents valid imem_rdata this cycle
//   imem_rdata   instruction word from memory
//   jump         decoder: take jump
//   branch       decoder: instruction is beq
//   zero         ALU zero flag
//   stall        hold the current instruction in execute
//   pc           address of the current instruction
//   pc_plus4     pc + 4 (combinational)
//   instr        instruction register
//   opcode       instr[31:26], to the decoder
//   instr_valid  instr is live and being executed (EXEC only)
//   retired      count of completed instructions, wraps at 2^32
//-----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] jump_target;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] next_pc;
  logic        fetch_done;
  logic        exec_done;

  //---------------------------------------------------------------------------
  // State register
  //---------------------------------------------------------------------------
  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  //---------------------------------------------------------------------------
  // Next-state logic
  //---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (imem_ready) state_d = EXEC;
      EXEC:    if (!stall)     state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Handshake completion strobes; imem_ready and stall only matter in their
  // own state, everywhere else they are ignored.
  assign fetch_done = (state_q == FETCH) && imem_ready;
  assign exec_done  = (state_q == EXEC)  && !stall;

  //---------------------------------------------------------------------------
  // Outputs decoded purely from registered state and pc, so they cannot
  // glitch on input changes.
  //---------------------------------------------------------------------------
  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == EXEC);
  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'd4;
  assign opcode      = instr[31:26];

  //---------------------------------------------------------------------------
  // Next-PC selection. Jump keeps the 256 MB region of pc+4; branch adds the
  // sign-extended word offset. All sums wrap modulo 2^32, and both targets
  // keep bits [1:0] at zero.
  //---------------------------------------------------------------------------
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_offset;

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

  //---------------------------------------------------------------------------
  // Datapath registers
  //---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      instr   <= 32'h0000_0000;
      retired <= 32'h0000_0000;
    end else begin
      if (fetch_done) begin
        instr <= imem_rdata;
      end
      if (exec_done) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
//-----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Three copies of the fetch unit with different reset PCs run in lockstep on
// shared stimulus; one is selected for checking at a time. A reference model
// tracks pc, instr and retired per instruction and computes next-PC targets
// arithmetically. Inputs are driven and outputs sampled around the falling
// clock edge, away from the active rising edge.
//-----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        stall = 1'b0;

  logic        req_w   [3];
  logic [31:0] addr_w  [3];
  logic [31:0] pc_w    [3];
  logic [31:0] pc4_w   [3];
  logic [31:0] instr_w [3];
  logic [5:0]  opc_w   [3];
  logic        valid_w [3];
  logic [31:0] ret_w   [3];

  int          sel = 0;
  logic        o_req;
  logic [31:0] o_addr;
  logic [31:0] o_pc;
  logic [31:0] o_pc4;
  logic [31:0] o_instr;
  logic [5:0]  o_opc;
  logic        o_valid;
  logic [31:0] o_ret;

  int          n_cmp  = 0;
  int          n_fail = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ret;

  always #5 clk = ~clk;

  function automatic logic [31:0] rpc(input int s);
    return (s == 0) ? 32'h0000_0000 : (s == 1) ? 32'hFFFF_FFFC : 32'h1000_0000;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    instr_fetch_unit #(.RESET_PC(rpc(g))) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (req_w[g]),
      .imem_addr   (addr_w[g]),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .jump        (jump),
      .branch      (branch),
      .zero        (zero),
      .stall       (stall),
      .pc          (pc_w[g]),
      .pc_plus4    (pc4_w[g]),
      .instr       (instr_w[g]),
      .opcode      (opc_w[g]),
      .instr_valid (valid_w[g]),
      .retired     (ret_w[g])
    );
  end

  always_comb begin
    o_req   = req_w[sel];
    o_addr  = addr_w[sel];
    o_pc    = pc_w[sel];
    o_pc4   = pc4_w[sel];
    o_instr = instr_w[sel];
    o_opc   = opc_w[sel];
    o_valid = valid_w[sel];
    o_ret   = ret_w[sel];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Next PC from the instruction-set rules: jump stays in the 256 MB region
  // of pc+4, a taken beq adds the signed word offset, otherwise pc+4.
  function automatic logic [31:0] ref_next_pc(input logic [31:0] cur_pc, input logic [31:0] word,
                                              input logic j, input logic b, input logic z);
    logic [31:0] seq;
    int          off;
    seq = cur_pc + 32'd4;
    off = $signed(word[15:0]);
    if (j)           return (seq & 32'hF000_0000) | ({6'b0, word[25:0]} << 2);
    else if (b && z) return seq + 32'(off * 4);
    else             return seq;
  endfunction

  // Reset asserted mid-cycle with a ready pending, then released for one
  // IDLE cycle; ends at a falling edge with the unit in FETCH.
  task automatic do_reset(input int s);
    sel     = s;
    m_pc    = rpc(s);
    m_instr = '0;
    m_ret   = '0;
    #2;
    imem_ready = 1'b1;
    imem_rdata = $urandom;
    rst_n      = 1'b0;
    #1;
    check("rst_req",   {31'b0, o_req},   32'd0);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_pc",    o_pc,    m_pc);
    check("rst_instr", o_instr, 32'd0);
    check("rst_opc",   {26'b0, o_opc}, 32'd0);
    check("rst_ret",   o_ret,   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_req",   {31'b0, o_req},   32'd0);
    check("idle_valid", {31'b0, o_valid}, 32'd0);
    check("idle_addr",  o_addr, m_pc);
    @(negedge clk);
  endtask

  // One complete instruction: FETCH with wait cycles, EXEC with stalls, exit.
  task automatic do_instr(input logic [31:0] word, input int waits,
                          input logic j, input logic b, input logic z, input int stalls);
    logic [31:0] exp_pc;
    check("fetch_req",   {31'b0, o_req},   32'd1);
    check("fetch_addr",  o_addr,  m_pc);
    check("fetch_valid", {31'b0, o_valid}, 32'd0);
    check("fetch_instr", o_instr, m_instr);
    jump   = 1'($urandom);
    branch = 1'($urandom);
    zero   = 1'($urandom);
    stall  = 1'($urandom);
    for (int w = 0; w < waits; w++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      check("wait_req",   {31'b0, o_req}, 32'd1);
      check("wait_addr",  o_addr,  m_pc);
      check("wait_instr", o_instr, m_instr);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    m_instr    = word;
    imem_ready = 1'($urandom);
    imem_rdata = $urandom;
    check("exec_valid", {31'b0, o_valid}, 32'd1);
    check("exec_req",   {31'b0, o_req},   32'd0);
    check("exec_instr", o_instr, word);
    check("exec_opc",   {26'b0, o_opc}, {26'b0, word[31:26]});
    check("exec_pc",    o_pc,  m_pc);
    check("exec_pc4",   o_pc4, m_pc + 32'd4);
    check("exec_ret",   o_ret, m_ret);
    for (int s = 0; s < stalls; s++) begin
      stall  = 1'b1;
      jump   = 1'($urandom);
      branch = 1'($urandom);
      zero   = 1'($urandom);
      @(negedge clk);
      check("stall_valid", {31'b0, o_valid}, 32'd1);
      check("stall_req",   {31'b0, o_req},   32'd0);
      check("stall_pc",    o_pc,    m_pc);
      check("stall_instr", o_instr, m_instr);
      check("stall_ret",   o_ret,   m_ret);
    end
    stall  = 1'b0;
    jump   = j;
    branch = b;
    zero   = z;
    exp_pc = ref_next_pc(m_pc, word, j, b, z);
    @(negedge clk);
    m_pc  = exp_pc;
    m_ret = m_ret + 32'd1;
    imem_ready = 1'b0;
    jump   = 1'b0;
    branch = 1'b0;
    zero   = 1'b0;
    check("next_addr",  o_addr, m_pc);
    check("next_req",   {31'b0, o_req},   32'd1);
    check("next_valid", {31'b0, o_valid}, 32'd0);
    check("next_ret",   o_ret,  m_ret);
  endtask

  initial begin
    logic [31:0] beq_w;
    logic [31:0] jmp40;
    logic [31:0] jmp400;
    beq_w  = 32'h1000_FFFE;          // beq, imm = -2 words
    jmp40  = {6'h02, 26'h000_0010};  // j 0x40
    jmp400 = {6'h02, 26'h000_0100};  // j 0x400 within region

    @(negedge clk);

    // Zero-wait memory returning add at every address.
    do_reset(0);
    for (int i = 0; i < 3; i++) do_instr(32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 0);
    check("ret_after3", o_ret, 32'd3);

    // Three wait cycles at pc 0, then branch cases at pc 0x40.
    do_reset(0);
    do_instr($urandom & 32'h03FF_FFFF, 3, 1'b0, 1'b0, 1'b0, 0);
    do_instr(jmp40, 0, 1'b1, 1'b0, 1'b0, 0);
    check("at_40", o_addr, 32'h0000_0040);
    do_instr(beq_w, 1, 1'b0, 1'b1, 1'b1, 0);
    check("beq_taken", o_addr, 32'h0000_003C);
    do_instr(jmp40, 0, 1'b1, 1'b0, 1'b0, 0);
    do_instr(beq_w, 0, 1'b0, 1'b1, 1'b0, 0);
    check("beq_not_taken", o_addr, 32'h0000_0044);

    // Five stall cycles, one retire on release.
    do_instr($urandom, 0, 1'b0, 1'b0, 1'b0, 5);
    check("stall_retire", o_ret, 32'd6);

    // Jump at 0x1000_0000, then jump competing with a taken branch.
    do_reset(2);
    do_instr(jmp400, 0, 1'b1, 1'b0, 1'b0, 0);
    check("jump_target", o_addr, 32'h1000_0400);
    do_instr(jmp400, 0, 1'b1, 1'b1, 1'b1, 0);
    check("jump_wins", o_addr, 32'h1000_0400);

    // Wrap from the top of the address space, then reset mid-FETCH.
    do_reset(1);
    do_instr(32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 0);
    check("wrap_addr", o_addr, 32'h0000_0000);
    do_reset(1);
    do_instr(32'h0000_0000, 2, 1'b0, 1'b0, 1'b0, 0);

    // Randomized instruction stream.
    do_reset(0);
    for (int i = 0; i < 60; i++) begin
      do_instr($urandom, $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0),
               1'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
